// File: rtl/tiny45_alu_pkg.sv
// Shared constants for the nibble-serial ALU, shifter and sequencer:
// opcodes, sequencer state encoding and word geometry.
package tiny45_alu_pkg;

    localparam int unsigned NIBBLES = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned DATA_W  = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return op[1:0] == 2'b01;
    endfunction

    function automatic logic is_slt(input logic [3:0] op);
        return op[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/tiny45_alu.sv
// One-nibble ALU slice: add/sub with carry chaining, logic ops, and a
// compare flag that chains equality or reports signed/unsigned less-than.
module tiny45_alu (
    input  logic [3:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cy_in,
    input  logic       cmp_in,
    output logic [3:0] d,
    output logic       cy_out,
    output logic       cmp_res
);

    logic       sub;
    logic [3:0] bx;
    logic [4:0] sum;
    logic       ovf;

    always_comb begin
        sub     = op[3] | (op[2:1] == 2'b01);
        bx      = sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, bx} + {4'b0, cy_in};
        ovf     = (a[3] == bx[3]) && (sum[3] != a[3]);
        d       = sum[3:0];
        cy_out  = sum[4];
        cmp_res = cmp_in & (a == b);
        // Less-than flags are only meaningful on the most significant nibble
        case (op[2:0])
            3'b111:  d = a & b;
            3'b110:  d = a | b;
            3'b100:  d = a ^ b;
            3'b010:  cmp_res = sum[3] ^ ovf;
            3'b011:  cmp_res = ~sum[4];
            default: ;
        endcase
    end

endmodule

// File: rtl/tiny45_shifter.sv
// Word shifter that returns one nibble of the shifted operand per cycle.
module tiny45_shifter (
    input  logic [3:0]  op,
    input  logic [2:0]  counter,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic [3:0]  d
);

    logic signed [31:0] sa;
    logic [31:0]        shifted;

    always_comb begin
        sa = $signed(a);
        if (!op[2])
            shifted = a << shamt;
        else if (op[3])
            shifted = 32'(sa >>> shamt);
        else
            shifted = a >> shamt;
        d = shifted[{counter, 2'b00} +: 4];
    end

endmodule

// File: rtl/tiny45_alu_seq.sv
// Sequencer stepping the nibble ALU/shifter over a 32-bit word, LSB first.
// Define TINY45_ALU_SEQ_PIPELINE_EN to accept a new request in the result handshake cycle.
module tiny45_alu_seq (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_d,
    output logic        res_cmp,
    output logic        busy
);
    import tiny45_alu_pkg::*;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               carry_reg;
    logic               cmp_reg;
    logic [3:0]         op_r;
    logic [DATA_W-1:0]  a_r;
    logic [DATA_W-1:0]  b_r;

    logic [3:0] a_nib, b_nib, alu_d, shf_d, nib_d;
    logic       alu_cy, alu_cmp, accept;

    always_comb begin
        a_nib = a_r[{counter, 2'b00} +: 4];
        b_nib = b_r[{counter, 2'b00} +: 4];
        nib_d = is_shift(op_r) ? shf_d : alu_d;
    end

    tiny45_alu u_alu (
        .op      (op_r),
        .a       (a_nib),
        .b       (b_nib),
        .cy_in   (carry_reg),
        .cmp_in  (cmp_reg),
        .d       (alu_d),
        .cy_out  (alu_cy),
        .cmp_res (alu_cmp)
    );

    tiny45_shifter u_shifter (
        .op      (op_r),
        .counter (counter),
        .a       (a_r),
        .shamt   (b_r[4:0]),
        .d       (shf_d)
    );

`ifdef TINY45_ALU_SEQ_PIPELINE_EN
    assign req_ready = (state == IDLE) || ((state == DONE) && res_ready && !flush);
`else
    assign req_ready = (state == IDLE);
`endif

    // flush blocks acceptance even while req_ready is high
    assign accept = req_valid && req_ready && !flush;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            counter   <= '0;
            carry_reg <= 1'b0;
            cmp_reg   <= 1'b1;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            res_d     <= '0;
            res_cmp   <= 1'b0;
            res_valid <= 1'b0;
        end else if (accept) begin
            op_r      <= req_op;
            a_r       <= req_a;
            b_r       <= req_b;
            counter   <= '0;
            carry_reg <= req_op[1] | req_op[3];
            cmp_reg   <= 1'b1;
            res_valid <= 1'b0;
            state     <= RUN;
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        res_d[{counter, 2'b00} +: 4] <= nib_d;
                        carry_reg <= alu_cy;
                        cmp_reg   <= alu_cmp;
                        counter   <= counter + CNT_W'(1);
                        // Last nibble: finalise compare and collapse set-less-than results
                        if (counter == CNT_W'(NIBBLES - 1)) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                            res_cmp   <= is_shift(op_r) ? 1'b0 : alu_cmp;
                            if (is_slt(op_r))
                                res_d <= {31'b0, alu_cmp};
                        end
                    end
                end
                DONE: begin
                    if (flush || res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny45_alu_seq.sv
// Randomised and directed bench for tiny45_alu_seq against a word-level reference model.
module tb_tiny45_alu_seq;
    import tiny45_alu_pkg::*;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_d;
    logic        res_cmp;
    logic        busy;

    int n_tests;
    int n_fail;

    tiny45_alu_seq dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_d     (res_d),
        .res_cmp   (res_cmp),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Word-level reference; cmp_known marks ops whose compare flag is defined
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic cmp, output logic cmp_known);
        d = '0;
        cmp = 1'b0;
        cmp_known = 1'b1;
        case (op)
            OP_ADD:  begin d = a + b; cmp_known = 1'b0; end
            OP_SUB:  begin d = a - b; cmp_known = 1'b0; end
            OP_SLT:  begin cmp = ($signed(a) < $signed(b)); d = {31'b0, cmp}; end
            OP_SLTU: begin cmp = (a < b); d = {31'b0, cmp}; end
            OP_AND:  begin d = a & b; cmp_known = 1'b0; end
            OP_OR:   begin d = a | b; cmp_known = 1'b0; end
            OP_XOR:  begin d = a ^ b; cmp = (a == b); end
            OP_SLL:  d = a << b[4:0];
            OP_SRL:  d = a >> b[4:0];
            OP_SRA:  d = 32'($signed(a) >>> b[4:0]);
            default: cmp_known = 1'b0;
        endcase
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        check("req_ready_idle", 32'(req_ready), 32'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    // Called #1 after the accepting edge; counts negedges until res_valid
    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("post_hs_valid", 32'(res_valid), 32'(0));
        check("post_hs_busy", 32'(busy), 32'(0));
        check("post_hs_ready", 32'(req_ready), 32'(1));
    endtask

    task automatic check_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_d;
        logic        exp_cmp, cmp_known;
        model(op, a, b, exp_d, exp_cmp, cmp_known);
        check("res_d", res_d, exp_d);
        if (cmp_known)
            check("res_cmp", 32'(res_cmp), 32'(exp_cmp));
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int          lat;
        logic [31:0] held;
        start_op(op, a, b);
        wait_result(lat);
        check("latency", 32'(lat), 32'(9));
        check_result(op, a, b);
        held = res_d;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_d", res_d, held);
            check("hold_valid", 32'(res_valid), 32'(1));
            check("hold_ready", 32'(req_ready), 32'(0));
        end
        finish_op();
    endtask

    logic [3:0] ops [10] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND,
                             OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA};

    initial begin
        int lat;
        n_tests   = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;
        res_ready = 1'b0;
        #12;
        check("rst_ready", 32'(req_ready), 32'(1));
        check("rst_valid", 32'(res_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_d", res_d, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed cases from the operation table
        run_op(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(OP_SUB,  32'h0000_0000, 32'h0000_0001, 0);
        run_op(OP_SLT,  32'h8000_0000, 32'h0000_0001, 0);
        run_op(OP_SLTU, 32'h8000_0000, 32'h0000_0001, 0);
        run_op(OP_XOR,  32'h1234_5678, 32'h1234_5678, 0);
        run_op(OP_XOR,  32'h1234_5678, 32'h1234_5679, 0);
        run_op(OP_SRA,  32'h8000_0000, 32'd31, 0);
        run_op(OP_SRL,  32'h8000_0000, 32'd31, 0);
        run_op(OP_SLL,  32'h0000_0001, 32'd4, 0);
        run_op(OP_AND,  32'h1234_5678, 32'h0F0F_0F0F, 5);

        // Result handshake with a request waiting
        start_op(OP_OR, 32'hA000_0005, 32'h0500_00A0);
        wait_result(lat);
        check("latency", 32'(lat), 32'(9));
        check_result(OP_OR, 32'hA000_0005, 32'h0500_00A0);
`ifdef TINY45_ALU_SEQ_PIPELINE_EN
        @(negedge clk);
        res_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_SUB;
        req_a     = 32'h0000_0010;
        req_b     = 32'h0000_0020;
        check("pipe_ready", 32'(req_ready), 32'(1));
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        req_valid = 1'b0;
        wait_result(lat);
        check("pipe_latency", 32'(lat), 32'(9));
        check_result(OP_SUB, 32'h0000_0010, 32'h0000_0020);
        finish_op();
`else
        @(negedge clk);
        res_ready = 1'b1;
        check("done_ready", 32'(req_ready), 32'(0));
        finish_op();
`endif

        // Flush at counter 3
        start_op(OP_ADD, 32'h1111_1111, 32'h2222_2222);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'(0));
        check("flush_ready", 32'(req_ready), 32'(1));
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) lat++;
        end
        check("flush_no_valid", 32'(lat), 32'(0));

        // Flush beats the result handshake in DONE
        start_op(OP_XOR, 32'h0000_00FF, 32'h0000_0F0F);
        wait_result(lat);
        check("latency", 32'(lat), 32'(9));
        @(negedge clk);
        flush     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        check("flush_done_valid", 32'(res_valid), 32'(0));
        check("flush_done_busy", 32'(busy), 32'(0));

        // Flush in IDLE rejects a presented request
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_ADD;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", 32'(busy), 32'(0));

        // Asynchronous reset mid-run
        start_op(OP_ADD, 32'hDEAD_BEEF, 32'h0101_0101);
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", 32'(res_valid), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_ready", 32'(req_ready), 32'(1));
        check("arst_d", res_d, 32'h0);
        check("arst_cmp", 32'(res_cmp), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        check("and_after_rst", res_d, 32'hF000_F000);

        // Random operations
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, 9)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(op, a, b, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
